tg_mux: RTL and testbench

TG_MUX -- requirements
Module: tg_mux

---
 rtl/tg_mux.sv | 118 +++++++++++
 tb/tb_tg_mux.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tg_mux.sv
// Transmission-gate style N:1 output mux with break-before-make switching.
// Gate enables are registered; the shared bus floats when nothing is connected.
module tg_mux #(
  parameter int WIDTH = 1,
  parameter int CH    = 4,
  parameter int DEAD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   a,
  input  logic                  req_valid,
  input  logic                  req_en,
  input  logic [3:0]            req_sel,
  output logic                  req_ready,
  output logic [WIDTH-1:0]      y,
  output logic [CH-1:0]         en_out,
  output logic                  busy,
  output logic                  err,
  output logic [7:0]            sw_cnt
);

  typedef enum logic {
    S_IDLE,
    S_BREAK
  } state_t;

  state_t          r_state, w_state_n;
  logic [CH-1:0]   r_en, w_en_n;
  logic [3:0]      r_cnt, w_cnt_n;
  logic [3:0]      r_sel, w_sel_n;
  logic            r_err, w_err_n;
  logic [7:0]      r_sw, w_sw_n;

  logic            w_acc;
  logic            w_bad;
  logic [CH-1:0]   w_hot;
  logic [CH-1:0]   w_hot_lat;
  logic [7:0]      w_sw_inc;
  logic [WIDTH-1:0] w_data;

  assign w_acc     = req_valid && (r_state == S_IDLE);
  assign w_bad     = {1'b0, req_sel} >= 5'(CH);
  assign w_hot     = CH'(1) << req_sel;
  assign w_hot_lat = CH'(1) << r_sel;
  assign w_sw_inc  = (r_sw == 8'hFF) ? r_sw : r_sw + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_en    <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_err   <= 1'b0;
      r_sw    <= '0;
    end else begin
      r_state <= w_state_n;
      r_en    <= w_en_n;
      r_cnt   <= w_cnt_n;
      r_sel   <= w_sel_n;
      r_err   <= w_err_n;
      r_sw    <= w_sw_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_en_n    = r_en;
    w_cnt_n   = r_cnt;
    w_sel_n   = r_sel;
    w_err_n   = 1'b0;
    w_sw_n    = r_sw;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (!req_en) begin
            w_en_n = '0;
          end else if (w_bad) begin
            w_err_n = 1'b1;
          end else if (r_en == '0) begin
            w_en_n = w_hot;
            w_sw_n = w_sw_inc;
          end else if (r_en != w_hot) begin
            // open the old gate first; the new one closes after the dead time
            w_en_n    = '0;
            w_sel_n   = req_sel;
            w_cnt_n   = 4'(DEAD - 1);
            w_state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_cnt == 4'd0) begin
          w_en_n    = w_hot_lat;
          w_sw_n    = w_sw_inc;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (r_en[i]) w_data = a[i*WIDTH +: WIDTH];
    end
  end

  assign y         = (|r_en) ? w_data : {WIDTH{1'bz}};
  assign en_out    = r_en;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_BREAK);
  assign err       = r_err;
  assign sw_cnt    = r_sw;

endmodule

// File: tb/tb_tg_mux.sv
// Directed bench for tg_mux (WIDTH=1, CH=4, DEAD=2).
module tb_tg_mux;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       req_valid;
  logic       req_en;
  logic [3:0] req_sel;
  logic       req_ready;
  wire        y;
  logic [3:0] en_out;
  logic       busy;
  logic       err;
  logic [7:0] sw_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  tg_mux #(.WIDTH(1), .CH(4), .DEAD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .req_valid (req_valid),
    .req_en    (req_en),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .y         (y),
    .en_out    (en_out),
    .busy      (busy),
    .err       (err),
    .sw_cnt    (sw_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    n_tests++;
    assert ($onehot0(en_out)) else begin
      n_fail++;
      $error("FAIL onehot0: observed %b expected at most one bit", en_out);
    end
  end

  initial begin
    rst       = 1'b0;
    a         = 4'b0100;
    req_valid = 1'b0;
    req_en    = 1'b0;
    req_sel   = 4'd0;
    #1 rst = 1'b1;
    #1;
    chk("rst_en_out", 32'(en_out), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_sw_cnt", 32'(sw_cnt), 32'h0);
    cyc();
    cyc();
    rst = 1'b0;

    // connect channel 2 from empty
    req_valid = 1'b1; req_en = 1'b1; req_sel = 4'd2;
    cyc();
    req_valid = 1'b0;
    chk("conn2_en", 32'(en_out), 32'h4);
    chk("conn2_y", 32'(y), 32'h1);
    chk("conn2_sw", 32'(sw_cnt), 32'h1);
    chk("conn2_busy", 32'(busy), 32'h0);

    // switch 2 -> 0 through a two-cycle dead time
    a = 4'b0001;
    req_valid = 1'b1; req_sel = 4'd0;
    cyc();
    req_valid = 1'b0;
    chk("brk1_en", 32'(en_out), 32'h0);
    chk("brk1_busy", 32'(busy), 32'h1);
    chk("brk1_ready", 32'(req_ready), 32'h0);
    req_valid = 1'b1; req_sel = 4'd3;
    cyc();
    req_valid = 1'b0;
    chk("brk2_en", 32'(en_out), 32'h0);
    chk("brk2_busy", 32'(busy), 32'h1);
    cyc();
    chk("sw0_en", 32'(en_out), 32'h1);
    chk("sw0_y", 32'(y), 32'h1);
    chk("sw0_sw", 32'(sw_cnt), 32'h2);
    chk("sw0_busy", 32'(busy), 32'h0);

    // same channel again: no change
    req_valid = 1'b1; req_sel = 4'd0;
    cyc();
    req_valid = 1'b0;
    chk("same_en", 32'(en_out), 32'h1);
    chk("same_busy", 32'(busy), 32'h0);
    chk("same_sw", 32'(sw_cnt), 32'h2);

    // out-of-range selection
    req_valid = 1'b1; req_sel = 4'd5;
    cyc();
    req_valid = 1'b0;
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_en", 32'(en_out), 32'h1);
    chk("bad_sw", 32'(sw_cnt), 32'h2);
    chk("bad_busy", 32'(busy), 32'h0);
    cyc();
    chk("bad_err_clr", 32'(err), 32'h0);

    // disconnect
    a = 4'b1111;
    req_valid = 1'b1; req_en = 1'b0; req_sel = 4'd0;
    cyc();
    req_valid = 1'b0;
    chk("dis_en", 32'(en_out), 32'h0);
    chk("dis_busy", 32'(busy), 32'h0);
    chk("dis_y_released", 32'(y === 1'b1), 32'h0);
    chk("dis_sw", 32'(sw_cnt), 32'h2);

    // connect 3 from empty
    req_valid = 1'b1; req_en = 1'b1; req_sel = 4'd3;
    cyc();
    req_valid = 1'b0;
    chk("conn3_en", 32'(en_out), 32'h8);
    chk("conn3_y", 32'(y), 32'h1);
    chk("conn3_sw", 32'(sw_cnt), 32'h3);

    // reset in the middle of a break
    req_valid = 1'b1; req_sel = 4'd1;
    cyc();
    req_valid = 1'b0;
    chk("rbrk_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rbrk_en", 32'(en_out), 32'h0);
    chk("rbrk_busy0", 32'(busy), 32'h0);
    chk("rbrk_sw", 32'(sw_cnt), 32'h0);
    chk("rbrk_ready", 32'(req_ready), 32'h1);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("rbrk_never", 32'(en_out), 32'h0);
    chk("rbrk_sw_hold", 32'(sw_cnt), 32'h0);

    // first edge after reset processes normally
    req_valid = 1'b1; req_sel = 4'd1;
    cyc();
    req_valid = 1'b0;
    chk("post_rst_en", 32'(en_out), 32'h2);
    chk("post_rst_sw", 32'(sw_cnt), 32'h1);

    // 260 alternating switches: counter saturates
    for (int k = 0; k < 260; k++) begin
      req_valid = 1'b1;
      req_sel   = (k % 2 == 0) ? 4'd0 : 4'd1;
      cyc();
      req_valid = 1'b0;
      cyc();
      cyc();
      if (k == 252) chk("sat_254", 32'(sw_cnt), 32'd254);
      if (k == 253) chk("sat_255", 32'(sw_cnt), 32'd255);
    end
    chk("sat_final", 32'(sw_cnt), 32'd255);
    chk("sat_en", 32'(en_out), 32'h2);
    chk("sat_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
